control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Clk  input  1  single clock; all state changes on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 Instr  input  32  current instruction from datapath; opcode Instr[31:26], func Instr[3:0].
REQ-004 Zero  input  1  ALU zero flag from datapath, valid combinationally in S_EXE.
REQ-005 PC_Sel  output  1  0 = PC+4, 1 = PC+4+Immed.
REQ-006 PC_LdEn  output  1  PC load enable, one cycle per retired instruction.
REQ-007 RF_WrEn  output  1  register file write enable.
REQ-008 RF_WrData_sel  output  1  0 = ALU_Out, 1 = MEM_Out.
REQ-009 RF_B_sel  output  1  0 = RF_B from Instr[15:11], 1 = RF_B from Instr[20:16].
REQ-010 ALU_Bin_sel  output  1  0 = RF_B, 1 = Immed.
REQ-011 ALU_func  output  4  0000 add, 0001 sub, 0010 and, 0011 or; others pass Instr[3:0].
REQ-012 Mem_WrEn  output  1  data memory write enable.
REQ-013 lb_MEM_trim  output  1  1 = byte-trim memory data on writeback.
REQ-014 State  output  3  current FSM state, for debug and bench.

Function
REQ-015 States, encoded in State: S_IF=0, S_DEC=1, S_EXE=2, S_MEM=3, S_WB=4; codes 5-7 unreachable and transition to S_IF.
REQ-016 IR (32-bit) captures Instr on the S_IF->S_DEC edge; all decoding after S_IF uses IR, not Instr.
REQ-017 Opcode classes:
- 100000 R-type, with ALU_func=IR[3:0].
- 111000 li, 111001 lui, 110000 addi, with ALU_func=0000.
- 110010 andi (0010), 110011 ori (0011).
- 111111 b.
- 000000 beq, 000001 bne.
- 000011 lb, 001111 lw, 011111 sw.
- Every other opcode is illegal.
REQ-018 Transitions:
- S_IF->S_DEC always.
- S_DEC->S_IF for an illegal opcode; otherwise S_DEC->S_EXE.
- S_EXE->S_WB for R-type/immediate; S_EXE->S_MEM for lb/lw/sw; S_EXE->S_IF for branches.
- S_MEM->S_WB for loads; S_MEM->S_IF for sw.
- S_WB->S_IF always.
REQ-019 Instruction latency in cycles: R/immediate 4; lw/lb 5; sw 4; branch 3; illegal 2.
REQ-020 Outputs are combinational from State, IR and Zero; every output not explicitly asserted in a state SHALL be 0.
REQ-021 Operand selects:
- ALU_Bin_sel=1 for immediate, load and store classes in S_EXE, S_MEM and S_WB.
- RF_B_sel=1 for sw, beq and bne in every state after S_IF.
- ALU_func is held stable from S_EXE through S_WB.
REQ-022 Branches, in S_EXE:
- ALU_func=0001 and ALU_Bin_sel=0.
- PC_LdEn=1.
- PC_Sel=1 for b, for beq when Zero=1, and for bne when Zero=0; otherwise PC_Sel=0.
REQ-023 sw: Mem_WrEn=1 in S_MEM for exactly one cycle, together with PC_LdEn=1 and PC_Sel=0.
REQ-024 Writeback, in S_WB:
- RF_WrEn=1, PC_LdEn=1 and PC_Sel=0.
- RF_WrData_sel=1 and ALU address path held (ALU_Bin_sel=1, ALU_func=0000) for loads.
- lb_MEM_trim=1 for lb only.
REQ-025 Illegal opcode: PC_LdEn=1 and PC_Sel=0 in S_DEC; no RF or memory write.
REQ-026 Per instruction, PC_LdEn, RF_WrEn and Mem_WrEn are each asserted at most one cycle, and PC_LdEn is asserted in the instruction's final state.

Reset
REQ-027 While Reset=1, the next state is S_IF and IR is cleared to 0.
REQ-028 While Reset=1, all outputs except State are forced to 0 combinationally, including a mid-instruction reset in S_MEM or S_WB, so no RF, memory or PC write occurs in the reset cycle.
REQ-029 After Reset is released, the first edge takes S_IF->S_DEC.

Verification
REQ-030 add r3,r1,r2 (op 100000, func 0000) -> State 0,1,2,4,0; RF_WrEn=1 and PC_LdEn=1 only in S_WB; ALU_func=0000, RF_WrData_sel=0.
REQ-031 lb (op 000011) -> State 0,1,2,3,4; in S_WB RF_WrEn=1, RF_WrData_sel=1 and lb_MEM_trim=1; Mem_WrEn=0 throughout.
REQ-032 sw (op 011111) -> in S_MEM Mem_WrEn=1, RF_B_sel=1, ALU_Bin_sel=1 and PC_LdEn=1; RF_WrEn never asserted; next state S_IF.
REQ-033 beq (op 000000) -> with Zero=1 in S_EXE, PC_Sel=1 and PC_LdEn=1; with Zero=0, PC_Sel=0; bne gives the inverse; b (111111) gives PC_Sel=1 regardless of Zero.
REQ-034 Reset asserted while in S_WB of an lw -> that cycle RF_WrEn=0 and PC_LdEn=0; next State=0; IR=0.
REQ-035 Illegal opcode 010101 -> State 0,1,0; PC_LdEn=1 in S_DEC with PC_Sel=0; RF_WrEn=0 and Mem_WrEn=0.

Source files
------------

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multi-cycle controller for a simple load/store datapath. Each instruction
// walks IF -> DEC -> (EXE) -> (MEM) -> (WB) -> IF. The instruction is latched
// into IR as IF hands over to DEC, and all decoding after IF uses IR.
//
// Ports
//   Clk            clock, all state changes on the rising edge
//   Reset          synchronous active-high reset
//   Instr[31:0]    instruction from the datapath (opcode [31:26], func [3:0])
//   Zero           ALU zero flag, used for conditional branches in EXE
//   PC_Sel         0 = PC+4, 1 = PC+4+Immed
//   PC_LdEn        PC load enable, one cycle per retired instruction
//   RF_WrEn        register file write enable
//   RF_WrData_sel  0 = ALU_Out, 1 = MEM_Out
//   RF_B_sel       0 = RF_B from Instr[15:11], 1 = from Instr[20:16]
//   ALU_Bin_sel    0 = RF_B, 1 = Immed
//   ALU_func[3:0]  ALU operation
//   Mem_WrEn       data memory write enable
//   lb_MEM_trim    byte-trim memory data on writeback
//   State[2:0]     current state (IF=0, DEC=1, EXE=2, MEM=3, WB=4)
// -----------------------------------------------------------------------------
module control_fsm (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        Zero,
   output logic        PC_Sel,
   output logic        PC_LdEn,
   output logic        RF_WrEn,
   output logic        RF_WrData_sel,
   output logic        RF_B_sel,
   output logic        ALU_Bin_sel,
   output logic [3:0]  ALU_func,
   output logic        Mem_WrEn,
   output logic        lb_MEM_trim,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_DEC = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] ir_reg;

   // Only opcode and func participate in control; the operand fields belong
   // to the datapath.
   logic ir_unused;
   assign ir_unused = ^ir_reg[25:4];

   // ------------------------------------------------------------------------
   // Opcode decode (from IR)
   // ------------------------------------------------------------------------
   logic [5:0] op;
   logic       is_r, is_imm, is_lw, is_lb, is_sw, is_b, is_beq, is_bne;
   logic       is_load, is_mem, is_branch, is_legal;
   logic [3:0] imm_func;

   assign op     = ir_reg[31:26];
   assign is_r   = (op == 6'b100000);
   assign is_imm = (op == 6'b111000) || (op == 6'b111001) || (op == 6'b110000) ||
                   (op == 6'b110010) || (op == 6'b110011);
   assign is_lb  = (op == 6'b000011);
   assign is_lw  = (op == 6'b001111);
   assign is_sw  = (op == 6'b011111);
   assign is_b   = (op == 6'b111111);
   assign is_beq = (op == 6'b000000);
   assign is_bne = (op == 6'b000001);

   assign is_load   = is_lb | is_lw;
   assign is_mem    = is_load | is_sw;
   assign is_branch = is_b | is_beq | is_bne;
   assign is_legal  = is_r | is_imm | is_mem | is_branch;

   // andi/ori select logic ops; li, lui and addi all use add.
   assign imm_func = (op == 6'b110010) ? 4'b0010 :
                     (op == 6'b110011) ? 4'b0011 : 4'b0000;

   // ------------------------------------------------------------------------
   // State and IR registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= S_IF;
         ir_reg    <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_IF)
            ir_reg <= Instr;
      end
   end

   assign State = state_reg;

   // ------------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      PC_Sel        = 1'b0;
      PC_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      Mem_WrEn      = 1'b0;
      lb_MEM_trim   = 1'b0;

      case (state_reg)
         S_IF: begin
            state_next = S_DEC;
         end

         S_DEC: begin
            RF_B_sel = is_sw | is_beq | is_bne;
            if (!is_legal) begin
               // Skip the instruction: retire it here with a plain PC+4.
               PC_LdEn    = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_EXE;
            end
         end

         S_EXE: begin
            RF_B_sel = is_sw | is_beq | is_bne;
            if (is_branch) begin
               // Compare via subtraction; Zero is valid in this cycle.
               ALU_func   = 4'b0001;
               PC_LdEn    = 1'b1;
               PC_Sel     = is_b | (is_beq & Zero) | (is_bne & ~Zero);
               state_next = S_IF;
            end else if (is_mem) begin
               ALU_Bin_sel = 1'b1;
               ALU_func    = 4'b0000;
               state_next  = S_MEM;
            end else begin
               ALU_Bin_sel = is_imm;
               ALU_func    = is_r ? ir_reg[3:0] : imm_func;
               state_next  = S_WB;
            end
         end

         S_MEM: begin
            RF_B_sel    = is_sw;
            ALU_Bin_sel = 1'b1;
            ALU_func    = 4'b0000;
            if (is_sw) begin
               Mem_WrEn   = 1'b1;
               PC_LdEn    = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_WB;
            end
         end

         S_WB: begin
            RF_WrEn       = 1'b1;
            PC_LdEn       = 1'b1;
            // Keep the EXE operation on the ALU so its output stays stable.
            ALU_Bin_sel   = is_imm | is_load;
            ALU_func      = is_r ? ir_reg[3:0] : (is_imm ? imm_func : 4'b0000);
            RF_WrData_sel = is_load;
            lb_MEM_trim   = is_lb;
            state_next    = S_IF;
         end

         default: begin
            state_next = S_IF;
         end
      endcase

      // Reset suppresses every write strobe in the same cycle, even mid
      // instruction.
      if (Reset) begin
         state_next    = S_IF;
         PC_Sel        = 1'b0;
         PC_LdEn       = 1'b0;
         RF_WrEn       = 1'b0;
         RF_WrData_sel = 1'b0;
         RF_B_sel      = 1'b0;
         ALU_Bin_sel   = 1'b0;
         ALU_func      = 4'b0000;
         Mem_WrEn      = 1'b0;
         lb_MEM_trim   = 1'b0;
      end
   end

endmodule
